// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver.
package ps2_keyboard_rx_pkg;

  // Scan-code-set-2 prefix bytes folded into key events.
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BRK   = 8'hF0;
  localparam logic [7:0] PREFIX_PAUSE = 8'hE1;

  // Bytes still to swallow after the E1 that opens the 8-byte Pause sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Serial frame position: start bit, eight data bits, parity, stop.
  typedef enum logic [1:0] {
    FR_START,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  // What a received byte means to the prefix FSM.
  typedef enum logic [2:0] {
    BC_KEY,
    BC_EXT,
    BC_BRK,
    BC_PAUSE,
    BC_IGNORE
  } byte_class_t;

  // Classify one good byte. Keyboard status/ack bytes come back as BC_IGNORE;
  // the caller still emits them when a prefix is pending.
  function automatic byte_class_t classify(input logic [7:0] b);
    byte_class_t cls;
    case (b)
      PREFIX_EXT:   cls = BC_EXT;
      PREFIX_BRK:   cls = BC_BRK;
      PREFIX_PAUSE: cls = BC_PAUSE;
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF:
                    cls = BC_IGNORE;
      default:      cls = BC_KEY;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock glitch filter,
// 11-bit frame FSM and inter-bit timeout. Produces one good byte (bvalid) or
// one error pulse (berr) per frame.
module ps2_frame
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 5600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic [7:0] rx_byte,
  output logic       bvalid,
  output logic       berr
);

  localparam int                FLT_W    = $clog2(FILTER + 1);
  localparam logic [FLT_W-1:0]  FLT_LAST = FLT_W'(FILTER - 1);
  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic             ck_meta, ck_sync, d_meta, d_sync;
  logic             ck_filt;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_flip, fall;

  frame_state_t     state, state_nxt;
  logic [2:0]       dcnt, dcnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             par, par_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             bvalid_nxt, berr_nxt;

  // Two-flop synchronisers for both asynchronous pins (idle level is high).
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; a blocking = here would collapse
  // the two synchroniser stages into one.
  always_ff @(posedge clock) begin
    if (reset) begin
      ck_meta <= 1'b1;
      ck_sync <= 1'b1;
      d_meta  <= 1'b1;
      d_sync  <= 1'b1;
    end else begin
      ck_meta <= ps2Ck;
      ck_sync <= ck_meta;
      d_meta  <= ps2D;
      d_sync  <= d_meta;
    end
  end

  // The filtered clock flips on the FILTER-th consecutive differing sample;
  // the data bit is taken on that same edge when the flip is 1 -> 0.
  assign flt_flip = (ck_sync != ck_filt) && (flt_cnt == FLT_LAST);
  assign fall     = flt_flip && ck_filt;

  // Glitch filter: any sample equal to the current level restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      ck_filt <= 1'b1;
      flt_cnt <= '0;
    end else if (ck_sync == ck_filt) begin
      flt_cnt <= '0;
    end else if (flt_flip) begin
      ck_filt <= ck_sync;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // Frame FSM state register and single-cycle result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FR_START;
      dcnt    <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tmo_cnt <= '0;
      bvalid  <= 1'b0;
      berr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      dcnt    <= dcnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      tmo_cnt <= tmo_nxt;
      bvalid  <= bvalid_nxt;
      berr    <= berr_nxt;
    end
  end

  // Next-state: advance one bit per filtered falling edge, judge parity/stop
  // on the last bit, and abandon a partial frame when the line goes quiet.
  // NOTE: every signal written below gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    dcnt_nxt   = dcnt;
    shreg_nxt  = shreg;
    par_nxt    = par;
    tmo_nxt    = tmo_cnt;
    bvalid_nxt = 1'b0;
    berr_nxt   = 1'b0;

    if (fall) begin
      tmo_nxt = '0;
      case (state)
        FR_START: begin
          // A high start bit is line noise, not a frame.
          if (!d_sync) begin
            state_nxt = FR_DATA;
            dcnt_nxt  = '0;
          end
        end
        FR_DATA: begin
          shreg_nxt = {d_sync, shreg[7:1]};
          dcnt_nxt  = dcnt + 3'd1;
          if (dcnt == 3'd7) state_nxt = FR_PARITY;
        end
        FR_PARITY: begin
          par_nxt   = d_sync;
          state_nxt = FR_STOP;
        end
        FR_STOP: begin
          state_nxt = FR_START;
          if (d_sync && (^{shreg, par})) bvalid_nxt = 1'b1;
          else                           berr_nxt   = 1'b1;
        end
        default: state_nxt = FR_START;
      endcase
    end else if (state != FR_START) begin
      if (tmo_cnt == TMO_LAST) begin
        state_nxt = FR_START;
        tmo_nxt   = '0;
        berr_nxt  = 1'b1;
      end else begin
        tmo_nxt = tmo_cnt + 1'b1;
      end
    end
  end

  // The shift register holds the completed byte until the next data bit.
  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard front end: turns raw PS/2 pins into strb/make/code/ext key
// events, folding the E0 (extended), F0 (break) and E1 (Pause) prefixes.
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 5600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);

  logic [7:0]  rx_byte;
  logic        bvalid, berr;

  logic        ext_flag, ext_flag_nxt;
  logic        brk_flag, brk_flag_nxt;
  logic [2:0]  skip, skip_nxt;
  logic        strb_nxt, make_nxt, ext_nxt;
  logic [7:0]  code_nxt;
  byte_class_t cls;

  ps2_frame #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_frame (
    .clock   (clock),
    .reset   (reset),
    .ps2Ck   (ps2Ck),
    .ps2D    (ps2D),
    .rx_byte (rx_byte),
    .bvalid  (bvalid),
    .berr    (berr)
  );

  // Frame errors leave the frame receiver already registered, so they show
  // up in the cycle right after the stop sample.
  assign err = berr;

  // Prefix flags, Pause skip counter and the held key-event outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      skip     <= '0;
      strb     <= 1'b0;
      make     <= 1'b0;
      code     <= 8'h00;
      ext      <= 1'b0;
    end else begin
      ext_flag <= ext_flag_nxt;
      brk_flag <= brk_flag_nxt;
      skip     <= skip_nxt;
      strb     <= strb_nxt;
      make     <= make_nxt;
      code     <= code_nxt;
      ext      <= ext_nxt;
    end
  end

  // Byte FSM: swallow Pause bytes, latch prefixes, drop status bytes, and
  // otherwise emit one event carrying and clearing the pending prefixes.
  always_comb begin
    ext_flag_nxt = ext_flag;
    brk_flag_nxt = brk_flag;
    skip_nxt     = skip;
    strb_nxt     = 1'b0;
    make_nxt     = make;
    code_nxt     = code;
    ext_nxt      = ext;
    cls          = classify(rx_byte);

    if (berr) begin
      ext_flag_nxt = 1'b0;
      brk_flag_nxt = 1'b0;
      skip_nxt     = '0;
    end else if (bvalid) begin
      if (skip != 3'd0) begin
        skip_nxt = skip - 3'd1;
      end else begin
        case (cls)
          BC_PAUSE: skip_nxt     = PAUSE_SKIP;
          BC_EXT:   ext_flag_nxt = 1'b1;
          BC_BRK:   brk_flag_nxt = 1'b1;
          default: begin
            // Status bytes only count as keys when a prefix makes them one.
            if (cls == BC_KEY || ext_flag || brk_flag) begin
              strb_nxt     = 1'b1;
              code_nxt     = rx_byte;
              make_nxt     = !brk_flag;
              ext_nxt      = ext_flag;
              ext_flag_nxt = 1'b0;
              brk_flag_nxt = 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames are driven while
// expected key/error events are queued; a monitor pops and compares on every
// strb or err pulse.
module tb_ps2_keyboard_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 5600;
  // Quarter PS/2 bit period in system clocks. The line is run much faster
  // than a real keyboard to keep the run short; 80 clocks per bit is still
  // far beyond the 2+FILTER pin-to-sample latency.
  localparam int Q = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2Ck;
  logic       ps2D;
  logic       strb;
  logic       make;
  logic [7:0] code;
  logic       ext;
  logic       err;

  typedef struct packed {
    logic       is_err;
    logic       ext;
    logic       make;
    logic [7:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  ps2_keyboard_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ps2Ck (ps2Ck),
    .ps2D  (ps2D),
    .strb  (strb),
    .make  (make),
    .code  (code),
    .ext   (ext),
    .err   (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_key(input logic [7:0] c, input logic mk, input logic ex);
    exp_t e;
    e.is_err = 1'b0;
    e.ext    = ex;
    e.make   = mk;
    e.code   = c;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    exp_q.push_back(e);
  endtask

  // Drive the first nbits bits of a frame; glitch_bit adds a 5-clock low
  // pulse on ps2Ck in the high phase after that bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0, input int nbits = 11,
                            input int glitch_bit = -1);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2D = bits[i];
      wait_clk(Q);
      ps2Ck = 1'b0;
      wait_clk(2 * Q);
      ps2Ck = 1'b1;
      wait_clk(Q);
      if (i == glitch_bit) begin
        ps2Ck = 1'b0;
        wait_clk(5);
        ps2Ck = 1'b1;
        wait_clk(Q);
      end
    end
    ps2D = 1'b1;
    wait_clk(4 * Q);
  endtask

  // Bounded wait for all queued events to be seen.
  task automatic drain(input string name);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_clk(1);
    check({name, "_missing_events"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clock);
      if (strb || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'({strb, err, code}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err)
            check("err_event", 32'({strb, err}), 32'(2'b01));
          else
            check($sformatf("key_%02h", e.code), 32'({strb, err, ext, make, code}),
                  32'({2'b10, e.ext, e.make, e.code}));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ps2Ck = 1'b1;
    ps2D  = 1'b1;
    fork
      monitor_loop();
    join_none
    wait_clk(4);
    check("reset_outputs", 32'({strb, make, code, ext, err}), 32'd0);
    reset = 1'b0;
    wait_clk(20);

    // Plain make code.
    push_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C);
    drain("make_1c");

    // Break: F0 alone gives nothing, F0 1C gives one release.
    push_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0);
    send_frame(8'h1C);
    drain("break_1c");

    // Extended break, then flags must be clear for the next key.
    push_key(8'h75, 1'b0, 1'b1);
    push_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    send_frame(8'h1C);
    drain("ext_break_75");

    // Pause sequence swallowed entirely, following key decodes.
    push_key(8'h29, 1'b1, 1'b0);
    send_frame(8'hE1);
    send_frame(8'h14);
    send_frame(8'h77);
    send_frame(8'hE1);
    send_frame(8'hF0);
    send_frame(8'h14);
    send_frame(8'hF0);
    send_frame(8'h77);
    send_frame(8'h29);
    drain("pause_seq");

    // Status byte ignored without prefix; fake shift E0 12 is a normal ext key.
    push_key(8'h1C, 1'b1, 1'b0);
    push_key(8'h12, 1'b1, 1'b1);
    send_frame(8'hAA);
    send_frame(8'h1C);
    send_frame(8'hE0);
    send_frame(8'h12);
    drain("ignore_and_fake_shift");

    // Parity error and stop-bit error each give err only.
    push_err();
    send_frame(8'h1C, 1'b1);
    push_err();
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("frame_errors");

    // An error discards a pending E0.
    push_err();
    push_key(8'h75, 1'b1, 1'b0);
    send_frame(8'hE0);
    send_frame(8'h75, 1'b1);
    send_frame(8'h75);
    drain("error_clears_prefix");

    // Timeout after 4 bits, then a clean frame.
    push_err();
    send_frame(8'h5A, 1'b0, 1'b0, 4);
    wait_clk(TIMEOUT + 200);
    drain("timeout_err");
    push_key(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A);
    drain("after_timeout_5a");

    // Idle noise: a high start bit and a 5-clock glitch with data low must
    // start nothing (a false start would end in a timeout error).
    ps2Ck = 1'b0;
    wait_clk(2 * Q);
    ps2Ck = 1'b1;
    wait_clk(Q);
    ps2D = 1'b0;
    wait_clk(Q);
    ps2Ck = 1'b0;
    wait_clk(5);
    ps2Ck = 1'b1;
    wait_clk(Q);
    ps2D = 1'b1;
    wait_clk(TIMEOUT + 200);

    // Glitch inside a frame must not add a bit.
    push_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 3);
    drain("glitch_in_frame");

    // Reset mid-frame with E0 pending: outputs clear, prefix discarded.
    send_frame(8'hE0);
    send_frame(8'hF0, 1'b0, 1'b0, 6);
    reset = 1'b1;
    wait_clk(2);
    check("midframe_reset_outputs", 32'({strb, make, code, ext, err}), 32'd0);
    reset = 1'b0;
    wait_clk(20);
    push_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C);
    drain("after_reset_1c");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
